vec_pack: RTL and testbench

Transmit-side counterpart of `vec_cat`. It accepts whole `VECTOR_WIDTH`-bit fingerprint vectors and packs them densely into a continuous stream of `BUS_WIDTH`-bit bus words, with no padding between vectors. It sits between the vector source (host DMA or reference-vector generator) and the bus FIFO that feeds `vec_cat`. `vec_cat` then recovers the original vectors from this stream.

---
 rtl/vec_pkg.sv | 36 +++
 rtl/vec_pack_buf.sv | 40 ++++
 rtl/vec_pack.sv | 131 +++++++++++++
 tb/tb_vec_pack.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// ---------------------------------------------------------------------------
// vec_pkg
// Shared constants and helpers for the vector packing/unpacking pair
// (vec_pack on the transmit side, vec_cat on the receive side).
//   DEF_BUS_WIDTH     : default bus word width
//   DEF_VECTOR_WIDTH  : default fingerprint vector width
//   DEF_VEC_ID_WIDTH  : default width of the accepted-vector counter
//   pack_state_e      : PACK / FLUSH state of the packer
//   clog2, fillWidth  : width helpers for the fill counter
// ---------------------------------------------------------------------------
package vec_pkg;

    localparam int DEF_BUS_WIDTH    = 96;
    localparam int DEF_VECTOR_WIDTH = 128;
    localparam int DEF_VEC_ID_WIDTH = 8;

    typedef enum logic {
        ST_PACK  = 1'b0,
        ST_FLUSH = 1'b1
    } pack_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // The fill counter must represent 0 .. BUS+VEC inclusive.
    function automatic int fillWidth(input int busWidth, input int vectorWidth);
        return clog2(busWidth + vectorWidth + 1);
    endfunction

endpackage

// File: rtl/vec_pack_buf.sv
// ---------------------------------------------------------------------------
// vec_pack_buf
// Combinational datapath of vec_pack: optional left shift of the packing
// buffer by one bus word, then insertion of a vector at a variable offset
// counted from the MSB.
//   i_Buf      : current buffer, valid data left-aligned
//   i_Fill     : valid bit count after any same-cycle shift (insert offset)
//   i_Vector   : vector to insert; all-zero when nothing is accepted
//   i_ShiftEn  : a bus word is consumed this cycle
//   o_BufNext  : next buffer contents
// ---------------------------------------------------------------------------
module vec_pack_buf
    import vec_pkg::*;
#(
    parameter  int BUS_WIDTH    = DEF_BUS_WIDTH,
    parameter  int VECTOR_WIDTH = DEF_VECTOR_WIDTH,
    localparam int BUF_W        = BUS_WIDTH + VECTOR_WIDTH,
    localparam int FILL_W       = fillWidth(BUS_WIDTH, VECTOR_WIDTH)
) (
    input  logic [BUF_W-1:0]        i_Buf,
    input  logic [FILL_W-1:0]       i_Fill,
    input  logic [VECTOR_WIDTH-1:0] i_Vector,
    input  logic                    i_ShiftEn,
    output logic [BUF_W-1:0]        o_BufNext
);

    logic [BUF_W-1:0] w_Shifted;
    logic [BUF_W-1:0] w_Placed;

    // Bits below the fill level are always zero, so the shifted buffer and
    // the placed vector never overlap and can simply be OR-ed. A final
    // padded word also shifts out completely, since its data sits in the
    // top BUS_WIDTH bits only.
    always_comb begin
        w_Shifted = i_ShiftEn ? (i_Buf << BUS_WIDTH) : i_Buf;
        w_Placed  = {i_Vector, {BUS_WIDTH{1'b0}}} >> i_Fill;
        o_BufNext = w_Shifted | w_Placed;
    end

endmodule

// File: rtl/vec_pack.sv
// ---------------------------------------------------------------------------
// vec_pack
// Packs whole VECTOR_WIDTH-bit vectors densely into BUS_WIDTH-bit bus words,
// MSB first, with no padding between vectors. The last vector of a batch
// forces a flush: the final word is zero-padded in its LSBs and flagged with
// o_Last.
//   clk, rst   : clock, synchronous active-low reset
//   i_Vector   : input vector (MSB is first on the stream)
//   i_Valid    : i_Vector valid
//   i_Last     : accepted vector closes the batch
//   o_Ready    : a vector can be accepted this cycle
//   o_Vector   : output bus word (MSB is first on the stream)
//   o_Valid    : o_Vector valid
//   o_Last     : final word of the batch
//   i_Read     : consumer takes the word this cycle
//   o_VecID    : number of vectors accepted since reset (wrapping)
// ---------------------------------------------------------------------------
module vec_pack
    import vec_pkg::*;
#(
    parameter int BUS_WIDTH    = DEF_BUS_WIDTH,
    parameter int VECTOR_WIDTH = DEF_VECTOR_WIDTH,
    parameter int VEC_ID_WIDTH = DEF_VEC_ID_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [VECTOR_WIDTH-1:0] i_Vector,
    input  logic                    i_Valid,
    input  logic                    i_Last,
    output logic                    o_Ready,
    output logic [BUS_WIDTH-1:0]    o_Vector,
    output logic                    o_Valid,
    output logic                    o_Last,
    input  logic                    i_Read,
    output logic [VEC_ID_WIDTH-1:0] o_VecID
);

    localparam int BUF_W  = BUS_WIDTH + VECTOR_WIDTH;
    localparam int FILL_W = fillWidth(BUS_WIDTH, VECTOR_WIDTH);

    localparam logic [FILL_W-1:0] BUS_F = FILL_W'(BUS_WIDTH);
    localparam logic [FILL_W-1:0] VEC_F = FILL_W'(VECTOR_WIDTH);

    logic [BUF_W-1:0]        r_Buf;
    logic [FILL_W-1:0]       r_Fill;
    pack_state_e             r_State;
    logic [VEC_ID_WIDTH-1:0] r_VecCnt;

    logic [BUF_W-1:0]        w_BufNext;
    logic [FILL_W-1:0]       w_FillEmit;
    logic [FILL_W-1:0]       w_FillNext;
    logic [VECTOR_WIDTH-1:0] w_InsVector;
    logic                    w_Flush;
    logic                    w_Valid;
    logic                    w_Last;
    logic                    w_Ready;
    logic                    w_Accept;
    logic                    w_Emit;

    // Ready looks only at registered state, never at i_Read, so a vector is
    // only accepted once fewer than a full word is buffered. That keeps
    // fill below BUS_WIDTH+VECTOR_WIDTH.
    always_comb begin
        w_Flush  = (r_State == ST_FLUSH);
        w_Valid  = (r_Fill >= BUS_F) | (w_Flush & (r_Fill != '0));
        w_Last   = w_Valid & w_Flush & (r_Fill <= BUS_F);
        w_Ready  = rst & ~w_Flush & (r_Fill < BUS_F);
        w_Accept = i_Valid & w_Ready;
        w_Emit   = w_Valid & i_Read;

        // The final word may be partial, in which case fill drops to zero
        // rather than by a full word.
        w_FillEmit = r_Fill;
        if (w_Emit) begin
            w_FillEmit = w_Last ? '0 : (r_Fill - BUS_F);
        end
        w_FillNext  = w_FillEmit + (w_Accept ? VEC_F : '0);
        w_InsVector = w_Accept ? i_Vector : '0;
    end

    vec_pack_buf #(
        .BUS_WIDTH    (BUS_WIDTH),
        .VECTOR_WIDTH (VECTOR_WIDTH)
    ) u_Buf (
        .i_Buf     (r_Buf),
        .i_Fill    (w_FillEmit),
        .i_Vector  (w_InsVector),
        .i_ShiftEn (w_Emit),
        .o_BufNext (w_BufNext)
    );

    // An accept with i_Last enters FLUSH; the o_Last word leaves it. Accept
    // and the last emit can never coincide, because FLUSH holds ready low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_Buf    <= '0;
            r_Fill   <= '0;
            r_State  <= ST_PACK;
            r_VecCnt <= '0;
        end else begin
            r_Buf  <= w_BufNext;
            r_Fill <= w_FillNext;
            if (w_Accept) begin
                r_VecCnt <= r_VecCnt + 1'b1;
            end
            case (r_State)
                ST_PACK: begin
                    if (w_Accept & i_Last) begin
                        r_State <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (w_Emit & w_Last) begin
                        r_State <= ST_PACK;
                    end
                end
                default: r_State <= ST_PACK;
            endcase
        end
    end

    // Outputs are forced quiet while reset is asserted.
    always_comb begin
        o_Ready  = w_Ready;
        o_Valid  = rst & w_Valid;
        o_Last   = rst & w_Last;
        o_Vector = rst ? r_Buf[BUF_W-1 -: BUS_WIDTH] : '0;
        o_VecID  = r_VecCnt;
    end

endmodule

// File: tb/tb_vec_pack.sv
// ---------------------------------------------------------------------------
// tb_vec_pack
// Self-checking bench for vec_pack with the default 96/128/8 widths. A
// bit-queue model of the stream predicts every output each cycle; emitted
// words are also reassembled into vectors and matched against those sent.
// ---------------------------------------------------------------------------
module tb_vec_pack;

    localparam int BW = 96;
    localparam int VW = 128;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [VW-1:0] i_Vector;
    logic          i_Valid;
    logic          i_Last;
    logic          o_Ready;
    logic [BW-1:0] o_Vector;
    logic          o_Valid;
    logic          o_Last;
    logic          i_Read;
    logic [IW-1:0] o_VecID;

    int total = 0;
    int bad   = 0;

    // Reference model: pending stream bits (front = next bit out), flush flag
    // and accepted-vector count.
    bit            mQ[$];
    bit            mFlush = 1'b0;
    int            mCnt = 0;

    // Loopback scoreboard and emitted-word log.
    logic [VW-1:0] sentQ[$];
    bit            obsBits[$];
    logic [BW-1:0] obsWords[$];
    bit            obsLast[$];

    logic [VW-1:0] vecA = 128'h000102030405060708090A0B0C0D0E0F;
    logic [VW-1:0] vecB = 128'h101112131415161718191A1B1C1D1E1F;
    logic [VW-1:0] vecC = 128'h202122232425262728292A2B2C2D2E2F;
    logic [BW-1:0] t1Words [4];

    vec_pack #(
        .BUS_WIDTH    (BW),
        .VECTOR_WIDTH (VW),
        .VEC_ID_WIDTH (IW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_Vector (i_Vector),
        .i_Valid  (i_Valid),
        .i_Last   (i_Last),
        .o_Ready  (o_Ready),
        .o_Vector (o_Vector),
        .o_Valid  (o_Valid),
        .o_Last   (o_Last),
        .i_Read   (i_Read),
        .o_VecID  (o_VecID)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] modelWord();
        logic [BW-1:0] w;
        w = '0;
        for (int i = 0; i < BW && i < mQ.size(); i++) begin
            w[BW-1-i] = mQ[i];
        end
        return w;
    endfunction

    function automatic logic [BW-1:0] wordAt(input int idx);
        return (idx < obsWords.size()) ? obsWords[idx] : '0;
    endfunction

    function automatic bit lastAt(input int idx);
        return (idx < obsLast.size()) ? obsLast[idx] : 1'b0;
    endfunction

    function automatic void clearLog();
        obsWords.delete();
        obsLast.delete();
    endfunction

    // One clock cycle: drive inputs after the falling edge, compare outputs
    // against the model, then advance the model with the same inputs.
    task automatic applyStimulus(input bit v, input logic [VW-1:0] vec, input bit l,
                                 input bit rd, output bit acc);
        int            pend;
        bit            eV;
        bit            eL;
        bit            eR;
        bit            dummy;
        bit            anyPad;
        logic [IW-1:0] eId;
        logic [VW-1:0] r;
        logic [VW-1:0] e;
        @(negedge clk);
        i_Valid  = v;
        i_Vector = vec;
        i_Last   = l;
        i_Read   = rd;
        #1;
        pend = mQ.size();
        eV   = (pend >= BW) || (mFlush && pend != 0);
        eL   = eV && mFlush && (pend <= BW);
        eR   = !mFlush && (pend < BW);
        eId  = mCnt[IW-1:0];
        checkOutput("valid", 128'(o_Valid), 128'(eV));
        checkOutput("last", 128'(o_Last), 128'(eL));
        checkOutput("ready", 128'(o_Ready), 128'(eR));
        checkOutput("word", 128'(o_Vector), 128'(modelWord()));
        checkOutput("vecid", 128'(o_VecID), 128'(eId));

        if (o_Valid && i_Read) begin
            obsWords.push_back(o_Vector);
            obsLast.push_back(o_Last);
            for (int i = 0; i < BW; i++) begin
                obsBits.push_back(o_Vector[BW-1-i]);
            end
            while (obsBits.size() >= VW) begin
                for (int i = 0; i < VW; i++) begin
                    r[VW-1-i] = obsBits.pop_front();
                end
                e = '0;
                if (sentQ.size() != 0) begin
                    e = sentQ.pop_front();
                end
                checkOutput("loopback", r, e);
            end
            if (o_Last) begin
                anyPad = 1'b0;
                foreach (obsBits[i]) begin
                    anyPad |= obsBits[i];
                end
                checkOutput("pad_zero", 128'(anyPad), 128'(0));
                obsBits.delete();
            end
        end

        acc = v && eR;
        if (eV && rd) begin
            for (int i = 0; i < ((pend < BW) ? pend : BW); i++) begin
                dummy = mQ.pop_front();
            end
            if (eL) begin
                mFlush = 1'b0;
            end
        end
        if (acc) begin
            for (int i = 0; i < VW; i++) begin
                mQ.push_back(vec[VW-1-i]);
            end
            mCnt++;
            sentQ.push_back(vec);
            if (l) begin
                mFlush = 1'b1;
            end
        end
    endtask

    task automatic sendVector(input logic [VW-1:0] vec, input bit l, input bit rd);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            applyStimulus(1'b1, vec, l, rd, acc);
            n++;
        end
        checkOutput("send_timeout", 128'(acc), 128'(1));
    endtask

    task automatic sendRandomRead(input logic [VW-1:0] vec, input bit l);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            applyStimulus(1'b1, vec, l, ($urandom_range(3) != 0), acc);
            n++;
        end
        checkOutput("rand_send_timeout", 128'(acc), 128'(1));
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        while ((mQ.size() != 0 || mFlush) && n < 50) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b1, acc);
            n++;
        end
        checkOutput("drain_timeout", 128'(n < 50), 128'(1));
        applyStimulus(1'b0, '0, 1'b0, 1'b1, acc);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst      = 1'b0;
        i_Valid  = 1'b0;
        i_Read   = 1'b0;
        i_Last   = 1'b0;
        i_Vector = '0;
        #1;
        checkOutput("rst_ready_low", 128'(o_Ready), 128'(0));
        checkOutput("rst_valid_low", 128'(o_Valid), 128'(0));
        @(negedge clk);
        #1;
        checkOutput("rst_valid", 128'(o_Valid), 128'(0));
        checkOutput("rst_last", 128'(o_Last), 128'(0));
        checkOutput("rst_word", 128'(o_Vector), 128'(0));
        checkOutput("rst_vecid", 128'(o_VecID), 128'(0));
        checkOutput("rst_ready", 128'(o_Ready), 128'(0));
        mQ.delete();
        mFlush = 1'b0;
        mCnt   = 0;
        sentQ.delete();
        obsBits.delete();
        clearLog();
        rst = 1'b1;
    endtask

    task automatic checkThreeVectorWords(input string tag);
        checkOutput({tag, "_count"}, 128'(obsWords.size()), 128'(4));
        for (int i = 0; i < 4; i++) begin
            checkOutput({tag, "_word"}, 128'(wordAt(i)), 128'(t1Words[i]));
            checkOutput({tag, "_lastflag"}, 128'(lastAt(i)), 128'(i == 3));
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit            acc;
        logic [VW-1:0] rv;
        bit            rl;

        t1Words[0] = 96'h000102030405060708090A0B;
        t1Words[1] = 96'h0C0D0E0F1011121314151617;
        t1Words[2] = 96'h18191A1B1C1D1E1F20212223;
        t1Words[3] = 96'h2425262728292A2B2C2D2E2F;

        rst      = 1'b0;
        i_Valid  = 1'b0;
        i_Read   = 1'b0;
        i_Last   = 1'b0;
        i_Vector = '0;
        doReset();

        $display("[TB] three-vector batch");
        sendVector(vecA, 1'b0, 1'b1);
        sendVector(vecB, 1'b0, 1'b1);
        sendVector(vecC, 1'b1, 1'b1);
        drain();
        checkThreeVectorWords("t1");

        $display("[TB] single vector with last");
        clearLog();
        sendVector(vecA, 1'b1, 1'b1);
        drain();
        checkOutput("t2_count", 128'(obsWords.size()), 128'(2));
        checkOutput("t2_word0", 128'(wordAt(0)), 128'(vecA[127:32]));
        checkOutput("t2_word1", 128'(wordAt(1)), 128'({vecA[31:0], 64'h0}));
        checkOutput("t2_last0", 128'(lastAt(0)), 128'(0));
        checkOutput("t2_last1", 128'(lastAt(1)), 128'(1));

        $display("[TB] backpressure");
        clearLog();
        sendVector(vecA, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, vecB, 1'b0, 1'b0, acc);
            checkOutput("bp_word", 128'(o_Vector), 128'(vecA[127:32]));
            checkOutput("bp_valid", 128'(o_Valid), 128'(1));
            checkOutput("bp_ready", 128'(o_Ready), 128'(0));
        end
        sendVector(vecB, 1'b0, 1'b1);
        sendVector(vecC, 1'b1, 1'b1);
        drain();
        checkThreeVectorWords("t3");

        $display("[TB] reset mid-batch");
        sendVector(vecA, 1'b0, 1'b1);
        sendVector(vecB, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, acc);
        doReset();
        sendVector(vecC, 1'b1, 1'b1);
        drain();
        checkOutput("t4_count", 128'(obsWords.size()), 128'(2));
        checkOutput("t4_word0", 128'(wordAt(0)), 128'(vecC[127:32]));
        checkOutput("t4_word1", 128'(wordAt(1)), 128'({vecC[31:0], 64'h0}));

        $display("[TB] random loopback");
        doReset();
        for (int k = 0; k < 300; k++) begin
            while ($urandom_range(3) == 0) begin
                applyStimulus(1'b0, '0, 1'b0, ($urandom_range(1) == 1), acc);
            end
            rv = {$urandom, $urandom, $urandom, $urandom};
            rl = (k == 299) || ($urandom_range(7) == 0);
            sendRandomRead(rv, rl);
        end
        drain();
        checkOutput("vecid_wrap", 128'(o_VecID), 128'(44));
        checkOutput("loopback_left", 128'(sentQ.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
